// File: rtl/reg_file.sv
// 16 x 8 register file: one synchronous write port, two combinational read ports.
// Asynchronous active-low reset clears every entry; r0 is an ordinary register.
module reg_file (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] val_in,
   input  logic       write_en,
   input  logic [3:0] wr_addr,
   input  logic [3:0] rd_addr1,
   input  logic [3:0] rd_addr2,
   output logic [7:0] val1_out,
   output logic [7:0] val2_out
);

   localparam int DATA_W = 8;
   localparam int ADDR_W = 4;
   localparam int DEPTH  = 2 ** ADDR_W;

   logic [DATA_W-1:0] regs [DEPTH];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
      end else if (write_en) begin
         regs[wr_addr] <= val_in;
      end
   end

   // No write-to-read bypass: reads see the stored value only.
   assign val1_out = regs[rd_addr1];
   assign val2_out = regs[rd_addr2];

endmodule

// File: tb/tb_reg_file.sv
// Randomized self-checking bench for reg_file against an array reference model.
module tb_reg_file;

   logic       clk;
   logic       reset;
   logic [7:0] val_in;
   logic       write_en;
   logic [3:0] wr_addr;
   logic [3:0] rd_addr1;
   logic [3:0] rd_addr2;
   logic [7:0] val1_out;
   logic [7:0] val2_out;

   logic [7:0] ref_mem [16];
   int n_checks = 0;
   int n_fail   = 0;

   reg_file u_dut (
      .clk      (clk),
      .reset    (reset),
      .val_in   (val_in),
      .write_en (write_en),
      .wr_addr  (wr_addr),
      .rd_addr1 (rd_addr1),
      .rd_addr2 (rd_addr2),
      .val1_out (val1_out),
      .val2_out (val2_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %02h expected %02h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
   endtask

   // Drive one write cycle at the falling edge, capture on the rising edge.
   task automatic cycle(input logic we, input logic [3:0] addr, input logic [7:0] data);
      @(negedge clk);
      write_en = we;
      wr_addr  = addr;
      val_in   = data;
      @(posedge clk);
      #1;
      if (reset && we) ref_mem[addr] = data;
   endtask

   task automatic check_all(input string tag);
      for (int i = 0; i < 16; i++) begin
         rd_addr1 = 4'(i);
         rd_addr2 = 4'(15 - i);
         #1;
         chk({tag, "_p1"}, val1_out, ref_mem[i]);
         chk({tag, "_p2"}, val2_out, ref_mem[15 - i]);
      end
   endtask

   initial begin
      reset    = 1'b0;
      write_en = 1'b0;
      wr_addr  = '0;
      val_in   = '0;
      rd_addr1 = '0;
      rd_addr2 = '0;
      model_clear();

      #2;
      check_all("por");
      @(negedge clk);
      reset = 1'b1;

      // Preload, then assert reset with no clock edge in between.
      cycle(1'b1, 4'd0, 8'h22);
      cycle(1'b1, 4'd5, 8'hFF);
      write_en = 1'b0;
      rd_addr1 = 4'd0;
      rd_addr2 = 4'd5;
      #1;
      chk("preload_r0", val1_out, 8'h22);
      chk("preload_r5", val2_out, 8'hFF);
      reset = 1'b0;
      model_clear();
      #1;
      chk("async_rst_r0", val1_out, 8'h00);
      chk("async_rst_r5", val2_out, 8'h00);
      check_all("async_rst");
      @(negedge clk);
      reset = 1'b1;

      // Basic write/read and dependent write.
      cycle(1'b1, 4'd0, 8'd34);
      rd_addr1 = 4'd0;
      #1;
      chk("basic_r0", val1_out, 8'd34);
      cycle(1'b1, 4'd1, 8'd10);
      rd_addr1 = 4'd1;
      rd_addr2 = 4'd0;
      #1;
      chk("basic_r1", val1_out, 8'd10);
      chk("basic_r0b", val2_out, 8'd34);
      cycle(1'b1, 4'd2, ref_mem[0] + ref_mem[1]);
      cycle(1'b0, 4'd2, 8'h00);
      rd_addr1 = 4'd0;
      rd_addr2 = 4'd2;
      #1;
      chk("dep_r0", val1_out, 8'd34);
      chk("dep_r2", val2_out, 8'd44);

      // Write disabled for several edges.
      for (int k = 0; k < 4; k++) cycle(1'b0, 4'd0, 8'h00);
      check_all("wr_dis");

      // Writes attempted while reset is held low.
      @(negedge clk);
      reset = 1'b0;
      model_clear();
      for (int k = 0; k < 3; k++) cycle(1'b1, 4'd3, 8'hAA);
      @(negedge clk);
      write_en = 1'b0;
      reset    = 1'b1;
      rd_addr1 = 4'd3;
      #1;
      chk("wr_in_rst_r3", val1_out, 8'h00);
      check_all("wr_in_rst");

      // Sweep with same-cycle read of the write address.
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         write_en = 1'b1;
         wr_addr  = 4'(i);
         val_in   = 8'hF0 | 8'(i);
         rd_addr1 = 4'(i);
         rd_addr2 = 4'(i);
         #1;
         chk("sweep_old1", val1_out, ref_mem[i]);
         chk("sweep_old2", val2_out, ref_mem[i]);
         @(posedge clk);
         #1;
         ref_mem[i] = 8'hF0 | 8'(i);
         chk("sweep_new1", val1_out, ref_mem[i]);
         chk("sweep_new2", val2_out, ref_mem[i]);
      end
      @(negedge clk);
      write_en = 1'b0;
      check_all("sweep_pairs");

      // Random traffic with occasional mid-operation reset pulses.
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         reset    = ($urandom_range(0, 39) != 0);
         write_en = 1'($urandom_range(0, 1));
         wr_addr  = 4'($urandom_range(0, 15));
         val_in   = 8'($urandom_range(0, 255));
         rd_addr1 = 4'($urandom_range(0, 15));
         rd_addr2 = ($urandom_range(0, 3) == 0) ? rd_addr1 : 4'($urandom_range(0, 15));
         if (!reset) model_clear();
         #1;
         chk("rnd_pre1", val1_out, ref_mem[rd_addr1]);
         chk("rnd_pre2", val2_out, ref_mem[rd_addr2]);
         @(posedge clk);
         #1;
         if (reset && write_en) ref_mem[wr_addr] = val_in;
         chk("rnd_post1", val1_out, ref_mem[rd_addr1]);
         chk("rnd_post2", val2_out, ref_mem[rd_addr2]);
      end
      @(negedge clk);
      reset    = 1'b1;
      write_en = 1'b0;
      check_all("final");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
